// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 set-2 key decoder.
//
// Contents:
//   ps2_state_t   prefix-tracking FSM states (IDLE, EXT, BRK, EXT_BRK)
//   SC_*          scancode constants: prefixes, BAT, arrow keys and WASD
//   DIR_*         bit positions of the four directions inside a held-bit nibble
//   arrow_mask    one-hot direction for an extended (E0-prefixed) arrow code
//   wasd_mask     one-hot direction for a plain W/A/S/D code
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  // Prefix and keyboard status bytes
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  // Arrow keys (only meaningful after an E0 prefix)
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;

  // WASD keys (plain, non-extended codes)
  localparam logic [7:0] SC_KEY_A = 8'h1C;
  localparam logic [7:0] SC_KEY_D = 8'h23;
  localparam logic [7:0] SC_KEY_W = 8'h1D;
  localparam logic [7:0] SC_KEY_S = 8'h1B;

  // Direction bit positions in the 4-bit held vectors
  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;

  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_ARROW_LEFT:  m[DIR_LEFT]  = 1'b1;
      SC_ARROW_RIGHT: m[DIR_RIGHT] = 1'b1;
      SC_ARROW_UP:    m[DIR_UP]    = 1'b1;
      SC_ARROW_DOWN:  m[DIR_DOWN]  = 1'b1;
      default:        m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] wasd_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_KEY_A: m[DIR_LEFT]  = 1'b1;
      SC_KEY_D: m[DIR_RIGHT] = 1'b1;
      SC_KEY_W: m[DIR_UP]    = 1'b1;
      SC_KEY_S: m[DIR_DOWN]  = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_scancode_ascii.sv
// ps2_scancode_ascii: combinational set-2 make code to uppercase ASCII map.
//
// Ports:
//   scancode  in   8  set-2 make code
//   hit       out  1  high when scancode has an ASCII mapping
//   ascii     out  8  mapped ASCII value (8'h00 when hit is low)
//
// Covers letters A-Z, digits 0-9 and the space bar. Everything else misses.
module ps2_scancode_ascii (
  input  logic [7:0] scancode,
  output logic       hit,
  output logic [7:0] ascii
);

  always_comb begin
    hit   = 1'b1;
    ascii = 8'h00;
    case (scancode)
      // Letters
      8'h1C: ascii = 8'h41; // A
      8'h32: ascii = 8'h42; // B
      8'h21: ascii = 8'h43; // C
      8'h23: ascii = 8'h44; // D
      8'h24: ascii = 8'h45; // E
      8'h2B: ascii = 8'h46; // F
      8'h34: ascii = 8'h47; // G
      8'h33: ascii = 8'h48; // H
      8'h43: ascii = 8'h49; // I
      8'h3B: ascii = 8'h4A; // J
      8'h42: ascii = 8'h4B; // K
      8'h4B: ascii = 8'h4C; // L
      8'h3A: ascii = 8'h4D; // M
      8'h31: ascii = 8'h4E; // N
      8'h44: ascii = 8'h4F; // O
      8'h4D: ascii = 8'h50; // P
      8'h15: ascii = 8'h51; // Q
      8'h2D: ascii = 8'h52; // R
      8'h1B: ascii = 8'h53; // S
      8'h2C: ascii = 8'h54; // T
      8'h3C: ascii = 8'h55; // U
      8'h2A: ascii = 8'h56; // V
      8'h1D: ascii = 8'h57; // W
      8'h22: ascii = 8'h58; // X
      8'h35: ascii = 8'h59; // Y
      8'h1A: ascii = 8'h5A; // Z
      // Digits
      8'h45: ascii = 8'h30; // 0
      8'h16: ascii = 8'h31; // 1
      8'h1E: ascii = 8'h32; // 2
      8'h26: ascii = 8'h33; // 3
      8'h25: ascii = 8'h34; // 4
      8'h2E: ascii = 8'h35; // 5
      8'h36: ascii = 8'h36; // 6
      8'h3D: ascii = 8'h37; // 7
      8'h3E: ascii = 8'h38; // 8
      8'h46: ascii = 8'h39; // 9
      // Space bar
      8'h29: ascii = 8'h20;
      default: begin
        hit   = 1'b0;
        ascii = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns a stream of PS/2 set-2 scancode bytes into held
// direction flags and an uppercase ASCII strobe.
//
// Ports:
//   clk          in   1  system clock, posedge
//   reset        in   1  asynchronous active-low reset
//   rx_data      in   8  received byte, qualified by rx_valid
//   rx_valid     in   1  one-cycle strobe per received byte
//   key_left     out  1  E0 6B or A held
//   key_right    out  1  E0 74 or D held
//   key_up       out  1  E0 75 or W held
//   key_down     out  1  E0 72 or S held
//   ascii_code   out  8  last mapped make-code ASCII value, held
//   ascii_valid  out  1  one-cycle pulse when ascii_code updates
//   proto_err    out  1  one-cycle pulse on prefix timeout or illegal prefix
//   dbg_state    out  2  current prefix FSM state (ps2_state_t encoding)
//
// Handshake: rx_valid is a fire-and-forget strobe with no ready; every cycle
// in which rx_valid is high delivers exactly one byte and the decoder always
// consumes it. All outputs are registered: a byte taken on edge N shows its
// effect after edge N.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_left,
  output logic       key_right,
  output logic       key_up,
  output logic       key_down,
  output logic [7:0] ascii_code,
  output logic       ascii_valid,
  output logic       proto_err,
  output logic [1:0] dbg_state
);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  // Arrow and WASD holds are tracked separately so releasing one source of
  // a direction does not drop the other.
  logic [3:0]    arrow_q, arrow_d;
  logic [3:0]    wasd_q, wasd_d;
  logic [7:0]    ascii_code_q, ascii_code_d;
  logic          ascii_valid_q, ascii_valid_d;
  logic          proto_err_q, proto_err_d;

  logic          lut_hit;
  logic [7:0]    lut_ascii;
  logic          is_ignored;

  ps2_scancode_ascii u_lut (
    .scancode (rx_data),
    .hit      (lut_hit),
    .ascii    (lut_ascii)
  );

  // Keyboard status replies and error bytes carry no key information.
  assign is_ignored = (rx_data == SC_ACK)  || (rx_data == SC_RESEND) ||
                      (rx_data == SC_ERR0) || (rx_data == SC_ERR1);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    arrow_d       = arrow_q;
    wasd_d        = wasd_q;
    ascii_code_d  = ascii_code_q;
    ascii_valid_d = 1'b0;
    proto_err_d   = 1'b0;

    if (rx_valid) begin
      // A byte always wins over a coincident timeout and restarts the timer.
      timer_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (rx_data == SC_BRK) begin
            state_d = ST_BRK;
          end else if (rx_data == SC_BAT) begin
            // Keyboard self-test completion: it has forgotten every key.
            arrow_d = 4'b0000;
            wasd_d  = 4'b0000;
          end else if (!is_ignored) begin
            wasd_d = wasd_q | wasd_mask(rx_data);
            if (lut_hit) begin
              ascii_code_d  = lut_ascii;
              ascii_valid_d = 1'b1;
            end
          end
        end

        ST_EXT: begin
          if (rx_data == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (rx_data == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            arrow_d = arrow_q | arrow_mask(rx_data);
            state_d = ST_IDLE;
          end
        end

        ST_BRK: begin
          if (rx_data == SC_BRK) begin
            state_d = ST_BRK;
          end else if (rx_data == SC_EXT) begin
            // F0 E0 is out of order; resynchronise on the E0.
            proto_err_d = 1'b1;
            state_d     = ST_EXT;
          end else begin
            wasd_d  = wasd_q & ~wasd_mask(rx_data);
            state_d = ST_IDLE;
          end
        end

        ST_EXT_BRK: begin
          if ((rx_data == SC_EXT) || (rx_data == SC_BRK)) begin
            proto_err_d = 1'b1;
          end else begin
            arrow_d = arrow_q & ~arrow_mask(rx_data);
          end
          state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A prefix is pending and no follow-up byte arrived this cycle.
      if (timer_q == TIMER_LAST) begin
        state_d     = ST_IDLE;
        timer_d     = '0;
        proto_err_d = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      arrow_q       <= 4'b0000;
      wasd_q        <= 4'b0000;
      ascii_code_q  <= 8'h00;
      ascii_valid_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      arrow_q       <= arrow_d;
      wasd_q        <= wasd_d;
      ascii_code_q  <= ascii_code_d;
      ascii_valid_q <= ascii_valid_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // Conflicting directions are passed through; the consumer decides priority.
  assign key_left    = arrow_q[DIR_LEFT]  | wasd_q[DIR_LEFT];
  assign key_right   = arrow_q[DIR_RIGHT] | wasd_q[DIR_RIGHT];
  assign key_up      = arrow_q[DIR_UP]    | wasd_q[DIR_UP];
  assign key_down    = arrow_q[DIR_DOWN]  | wasd_q[DIR_DOWN];
  assign ascii_code  = ascii_code_q;
  assign ascii_valid = ascii_valid_q;
  assign proto_err   = proto_err_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits between the Ps2Interface receiver and the VGA controller.
- Consumes received set-2 scancode bytes and tracks E0 (extended) and F0 (break) prefixes in a small FSM.
- Produces level-held direction flags (arrows or WASD) that replace the sw[3:0] movement inputs.
- Produces a latched uppercase ASCII code plus a one-cycle valid strobe; these feed the ASCII/sprite lookup path.

Parameters:
- TIMEOUT_CYCLES, 2000000, clk cycles allowed between a prefix byte and its follow-up byte (20 ms at 100 MHz).
- TW, $clog2(TIMEOUT_CYCLES), width of the timeout counter.

Ports:
- clk  in  1  100 MHz system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte.
- key_left  out  1  high while E0 6B or 1C (A) is held.
- key_right  out  1  high while E0 74 or 23 (D) is held.
- key_up  out  1  high while E0 75 or 1D (W) is held.
- key_down  out  1  high while E0 72 or 1B (S) is held.
- ascii_code  out  8  last mapped make-code ASCII value; holds between updates.
- ascii_valid  out  1  one-cycle pulse when ascii_code is updated.
- proto_err  out  1  one-cycle pulse on prefix timeout or illegal prefix sequence.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM to IDLE, timer 0.
  - All 8 internal held bits 0, so key_* = 0.
  - ascii_code = 8'h00, ascii_valid = 0, proto_err = 0.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> BRK.
  - AA (BAT) -> clear all held bits, stay IDLE.
  - FA, FE, 00, FF ignored.
  - Any other byte is a normal make: set its held bit if it is W/A/S/D; ASCII lookup.
- EXT transitions:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT, restart timer.
  - Other byte: extended make; set arrow held bit if mapped; -> IDLE. Extended makes never produce ASCII.
- BRK transitions:
  - F0 -> stay BRK, restart timer.
  - E0 -> proto_err, -> EXT.
  - Other byte: clear matching WASD held bit; -> IDLE. Break codes never produce ASCII.
- EXT_BRK transitions:
  - Any byte except E0/F0: clear matching arrow held bit; -> IDLE.
  - E0 or F0: proto_err, -> IDLE.
- Direction outputs: each key_* is the OR of its arrow held bit and its WASD held bit. Conflicting directions (left and right together) are passed through unresolved; the consumer prioritises.
- ASCII map (uppercase only):
  - Letters A-Z (1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A) map to 41-5A.
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to 30-39.
  - 29 maps to 20 (space).
  - Unmapped codes: no update, no ascii_valid.
- Typematic repeats: every repeated make of a mapped key re-pulses ascii_valid; held bits are idempotent.
- Latency: byte accepted at cycle N; key_*, ascii_code, ascii_valid and proto_err are registered and visible at cycle N+1.
- Timeout:
  - Timer counts only in non-IDLE states with rx_valid low.
  - On reaching TIMEOUT_CYCLES-1: -> IDLE, proto_err pulse, held bits unchanged.
  - If rx_valid coincides with expiry, the byte wins: it is processed in the current state and no error is raised.
- Any byte received clears the timer.
- Reset asserted mid-sequence discards the pending prefix; there is no partial update.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state enum.
  - Scancode constants: SC_EXT=E0, SC_BRK=F0, SC_BAT=AA, the arrow codes, and the WASD codes.
- One sub-module ps2_scancode_ascii: purely combinational, 8-bit scancode in, {hit, ascii[7:0]} out.
- FSM, timer and held-bit registers stay in the top module.

Test Plan:
- Send 1C -> ascii_code=41, ascii_valid pulses once at N+1, key_left=1.
- Then send F0 1C -> key_left=0, ascii_code stays 41, no ascii_valid.
- Send E0 75 -> key_up=1, no ascii_valid.
- Then send E0 F0 75 -> key_up=0.
- Send E0 6B and 1C, then release only E0 F0 6B -> key_left stays 1 until F0 1C.
- Send E0, then idle TIMEOUT_CYCLES (use 100 in sim) -> proto_err pulses once, state IDLE.
- Then send 72 -> treated as a normal make, key_down unchanged (72 alone is unmapped).
- Send F0 then E0 -> proto_err pulses at N+1, FSM in EXT.
- Then send 72 -> key_down=1.
- Hold W, D and the down arrow, then send AA -> all key_* = 0.
- Hold W, D and the down arrow again; assert reset mid E0 F0 sequence -> all outputs 0 immediately (asynchronous).
- After deassert, send 16 -> ascii_code=31, ascii_valid pulse.
